// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath control lines.
module multicycle_control #(
  parameter int RESET_PC_EN = 1,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op_code,
  input  logic [DATA_W-1:0] alu_output_value,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_write,
  output logic              mem_addr_sel,
  output logic              ir_load,
  output logic              alu_src1_sel,
  output logic              alu_src2_sel,
  output logic [6:0]        alu_op_code,
  output logic              reg_write,
  output logic [1:0]        wb_sel,
  output logic              pc_load,
  output logic [1:0]        pc_src,
  output logic              pc_reset,
  output logic              halted,
  output logic [DATA_W-1:0] instret_count
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC,
    CL_NONE
  } iclass_t;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_ALU    = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  state_t     state;
  iclass_t    iclass;
  logic [6:0] opcode_q;
  logic       boot;

  function automatic iclass_t decode_class(input logic [6:0] op);
    iclass_t c;
    case (op)
      7'h33:   c = CL_R;
      7'h13:   c = CL_I;
      7'h03:   c = CL_LOAD;
      7'h23:   c = CL_STORE;
      7'h63:   c = CL_BRANCH;
      7'h6F:   c = CL_JAL;
      7'h67:   c = CL_JALR;
      7'h37:   c = CL_LUI;
      7'h17:   c = CL_AUIPC;
      default: c = CL_NONE;
    endcase
    return c;
  endfunction

  // {src1, src2}: src1 0=rs1/1=PC, src2 0=rs2/1=imm; LUI ignores the ALU
  function automatic logic [1:0] operand_sel(input iclass_t c);
    logic [1:0] s;
    case (c)
      CL_I, CL_LOAD, CL_STORE, CL_JALR: s = 2'b01;
      CL_JAL, CL_AUIPC:                 s = 2'b11;
      default:                          s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] wb_source(input iclass_t c);
    logic [1:0] w;
    case (c)
      CL_LOAD:          w = WB_LOAD;
      CL_JAL, CL_JALR:  w = WB_PC4;
      CL_LUI:           w = WB_IMM;
      default:          w = WB_ALU;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      iclass        <= CL_NONE;
      opcode_q      <= '0;
      boot          <= (RESET_PC_EN != 0);
      instret_count <= '0;
    end else begin
      if (pc_load) begin
        instret_count <= instret_count + DATA_W'(1);
      end
      if (boot) begin
        boot <= 1'b0;
      end else begin
        case (state)
          FETCH: begin
            if (mem_ready) begin
              state <= DECODE;
            end
          end
          DECODE: begin
            iclass   <= decode_class(op_code);
            opcode_q <= op_code;
            if (decode_class(op_code) == CL_NONE) begin
              state <= HALT;
            end else begin
              state <= EXECUTE;
            end
          end
          EXECUTE: begin
            case (iclass)
              CL_BRANCH:         state <= FETCH;
              CL_LOAD, CL_STORE: state <= MEMORY;
              default:           state <= WRITEBACK;
            endcase
          end
          MEMORY: begin
            if (mem_ready) begin
              state <= (iclass == CL_STORE) ? FETCH : WRITEBACK;
            end
          end
          WRITEBACK: state <= FETCH;
          HALT:      state <= HALT;
          default:   state <= FETCH;
        endcase
      end
    end
  end

  // Outputs decode from state and latched class; reset gates them off asynchronously
  always_comb begin
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    alu_src1_sel = 1'b0;
    alu_src2_sel = 1'b0;
    alu_op_code  = '0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    pc_load      = 1'b0;
    pc_src       = PC_SEQ;
    pc_reset     = 1'b0;
    halted       = 1'b0;
    if (!reset) begin
      if (boot) begin
        pc_reset = 1'b1;
      end else begin
        case (state)
          FETCH: begin
            mem_req = 1'b1;
            ir_load = mem_ready;
          end
          EXECUTE: begin
            alu_op_code                  = opcode_q;
            {alu_src1_sel, alu_src2_sel} = operand_sel(iclass);
            if (iclass == CL_BRANCH) begin
              pc_load = 1'b1;
              pc_src  = (alu_output_value != '0) ? PC_BRANCH : PC_SEQ;
            end
          end
          MEMORY: begin
            mem_req                      = 1'b1;
            mem_addr_sel                 = 1'b1;
            mem_write                    = (iclass == CL_STORE);
            alu_op_code                  = opcode_q;
            {alu_src1_sel, alu_src2_sel} = operand_sel(iclass);
            pc_load                      = mem_ready && (iclass == CL_STORE);
          end
          WRITEBACK: begin
            reg_write = 1'b1;
            pc_load   = 1'b1;
            wb_sel    = wb_source(iclass);
            pc_src    = (iclass == CL_JAL || iclass == CL_JALR) ? PC_ALU : PC_SEQ;
          end
          HALT: halted = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
